// File: rtl/factor_pkg.sv
// factor_pkg: types and constants shared by the answer judge and the game
// controller. It holds the judge FSM state encoding, the JUDG result codes
// seen on JUDG_OUT / JUDG_IN, and the hit-point counter width.
package factor_pkg;

    localparam int HP_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        GET_P,
        GET_Q,
        CHECK,
        SHOW,
        OVER
    } state_t;

    typedef enum logic [1:0] {
        JUDG_NONE = 2'b00,
        JUDG_OK   = 2'b01,
        JUDG_NG   = 2'b10,
        JUDG_OVER = 2'b11
    } judg_t;

endpackage

// File: rtl/factor_check.sv
// factor_check: combinational factorisation check.
// It tests whether (x+p)(x+q) expands to x^2 + b*x + c.
//   p, q  in  P_W      signed factor constants
//   b     in  P_W+1    signed linear coefficient
//   c     in  2*P_W    signed constant coefficient
//   match out 1        (p+q == b) && (p*q == c)
// The sum and the product are formed at full width, so neither can wrap.
module factor_check #(
    parameter int P_W = 5
) (
    input  logic signed [P_W-1:0]   p,
    input  logic signed [P_W-1:0]   q,
    input  logic signed [P_W:0]     b,
    input  logic signed [2*P_W-1:0] c,
    output logic                    match
);

    logic signed [P_W:0]     sum;
    logic signed [2*P_W-1:0] prod;
    logic signed [2*P_W-1:0] p_ext;
    logic signed [2*P_W-1:0] q_ext;

    always_comb begin
        p_ext = {{P_W{p[P_W-1]}}, p};
        q_ext = {{P_W{q[P_W-1]}}, q};
        sum   = {p[P_W-1], p} + {q[P_W-1], q};
        prod  = p_ext * q_ext;
        match = (sum == b) && (prod == c);
    end

endmodule

// File: rtl/factor_judge.sv
// factor_judge: answer-judging stage in front of the game controller.
// It latches a question, collects the factors p then q, judges the answer
// once, and tracks the player's hit points.
//   CLK, RST            clock and synchronous active-low reset
//   QUE_VALID/B/C       new question strobe and its coefficients
//   ANS_IN, ENTER, CLR  entry value, commit strobe, discard-last strobe
//   JUDG_OUT            00 none, 01 correct, 10 wrong, 11 game over
//   WRONG_OUT           one-cycle pulse for each wrong or timed-out answer
//   HP_OUT              remaining hit points
//   BUSY                high while a question is open (GET_P, GET_Q, CHECK)
module factor_judge
    import factor_pkg::*;
#(
    parameter int P_W        = 5,
    parameter int TIME_LIMIT = 1024,
    parameter int HP_INIT    = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              QUE_VALID,
    input  logic [P_W:0]      QUE_B,
    input  logic [2*P_W-1:0]  QUE_C,
    input  logic [P_W-1:0]    ANS_IN,
    input  logic              ENTER,
    input  logic              CLR,
    output logic [1:0]        JUDG_OUT,
    output logic              WRONG_OUT,
    output logic [HP_W-1:0]   HP_OUT,
    output logic              BUSY
);

    // One spare bit lets an ENTER of p in the expiry cycle carry the timer
    // to TIME_LIMIT without wrapping, so GET_Q then expires immediately.
    localparam int            TW     = $clog2(TIME_LIMIT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIME_LIMIT - 1);

    state_t             state, state_nxt;
    logic [TW-1:0]      timer;
    logic [P_W-1:0]     p, q;
    logic [P_W:0]       b;
    logic [2*P_W-1:0]   c;
    logic               forced_ng;
    logic [HP_W-1:0]    hp;
    logic [HP_W-1:0]    hp_dec;
    judg_t              judg;
    logic               wrong;
    logic               busy;
    logic               match;
    logic               expired;
    logic               answer_ok;
    logic               latch_que, latch_p, latch_q, drop_p, expire, judge;

    factor_check #(.P_W(P_W)) u_check (
        .p     (p),
        .q     (q),
        .b     (b),
        .c     (c),
        .match (match)
    );

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_que = 1'b0;
        latch_p   = 1'b0;
        latch_q   = 1'b0;
        drop_p    = 1'b0;
        expire    = 1'b0;
        judge     = 1'b0;
        expired   = (timer >= T_LAST);
        answer_ok = match && !forced_ng;
        hp_dec    = (hp != '0) ? hp - 1'b1 : hp;
        case (state)
            IDLE, SHOW: if (QUE_VALID) begin
                latch_que = 1'b1;
                state_nxt = GET_P;
            end
            GET_P: begin
                if (ENTER) begin
                    latch_p   = 1'b1;
                    state_nxt = GET_Q;
                end else if (expired) begin
                    expire    = 1'b1;
                    state_nxt = CHECK;
                end
            end
            GET_Q: begin
                // ENTER beats both expiry and CLR in the same cycle.
                if (ENTER) begin
                    latch_q   = 1'b1;
                    state_nxt = CHECK;
                end else if (expired) begin
                    expire    = 1'b1;
                    state_nxt = CHECK;
                end else if (CLR) begin
                    drop_p    = 1'b1;
                    state_nxt = GET_P;
                end
            end
            CHECK: begin
                judge = 1'b1;
                if (answer_ok || hp_dec != '0) state_nxt = SHOW;
                else                           state_nxt = OVER;
            end
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            timer     <= '0;
            p         <= '0;
            q         <= '0;
            b         <= '0;
            c         <= '0;
            forced_ng <= 1'b0;
            hp        <= HP_W'(HP_INIT);
            judg      <= JUDG_NONE;
            wrong     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wrong <= 1'b0;
            busy  <= (state_nxt == GET_P) || (state_nxt == GET_Q) ||
                     (state_nxt == CHECK);
            if (latch_que) begin
                b         <= QUE_B;
                c         <= QUE_C;
                timer     <= '0;
                forced_ng <= 1'b0;
                judg      <= JUDG_NONE;
            end
            // The timer keeps running across a CLR.
            if (state == GET_P || state == GET_Q) timer <= timer + 1'b1;
            if (latch_p) p <= ANS_IN;
            if (latch_q) q <= ANS_IN;
            if (drop_p)  p <= '0;
            if (expire)  forced_ng <= 1'b1;
            if (judge) begin
                if (answer_ok) begin
                    judg <= JUDG_OK;
                end else begin
                    wrong <= 1'b1;
                    hp    <= hp_dec;
                    judg  <= (hp_dec == '0) ? JUDG_OVER : JUDG_NG;
                end
            end
        end
    end

    assign JUDG_OUT  = judg;
    assign WRONG_OUT = wrong;
    assign HP_OUT    = hp;
    assign BUSY      = busy;

endmodule

// File: tb/tb_factor_judge.sv
module tb_factor_judge;

    localparam int P_W = 5;
    localparam int TL  = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             QUE_VALID = 1'b0;
    logic [P_W:0]     QUE_B = '0;
    logic [2*P_W-1:0] QUE_C = '0;
    logic [P_W-1:0]   ANS_IN = '0;
    logic             ENTER = 1'b0;
    logic             CLR = 1'b0;
    logic [1:0]       JUDG_OUT;
    logic             WRONG_OUT;
    logic [1:0]       HP_OUT;
    logic             BUSY;

    int checks = 0;
    int errors = 0;

    factor_judge #(.P_W(P_W), .TIME_LIMIT(TL), .HP_INIT(3)) dut (
        .CLK(CLK), .RST(RST), .QUE_VALID(QUE_VALID), .QUE_B(QUE_B),
        .QUE_C(QUE_C), .ANS_IN(ANS_IN), .ENTER(ENTER), .CLR(CLR),
        .JUDG_OUT(JUDG_OUT), .WRONG_OUT(WRONG_OUT), .HP_OUT(HP_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ask(input int bv, input int cv);
        QUE_VALID = 1'b1;
        QUE_B = 6'(bv);
        QUE_C = 10'(cv);
        tick();
        QUE_VALID = 1'b0;
    endtask

    task automatic enter(input int v);
        ANS_IN = 5'(v);
        ENTER = 1'b1;
        tick();
        ENTER = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick(); tick();
        checks++; if (JUDG_OUT !== 2'b00) begin errors++; $display("FAIL reset_judg got %b exp 00", JUDG_OUT); end
        checks++; if (WRONG_OUT !== 1'b0) begin errors++; $display("FAIL reset_wrong got %b exp 0", WRONG_OUT); end
        checks++; if (HP_OUT !== 2'd3) begin errors++; $display("FAIL reset_hp got %0d exp 3", HP_OUT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_correct();
        ask(5, 6);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL correct_busy_rise got %b exp 1", BUSY); end
        enter(2);
        enter(3);
        // CHECK cycle: nothing published yet.
        checks++; if (JUDG_OUT !== 2'b00 || BUSY !== 1'b1) begin errors++; $display("FAIL correct_check_cycle got judg %b busy %b exp 00 1", JUDG_OUT, BUSY); end
        tick();
        checks++; if (JUDG_OUT !== 2'b01) begin errors++; $display("FAIL correct_judg got %b exp 01", JUDG_OUT); end
        checks++; if (HP_OUT !== 2'd3 || WRONG_OUT !== 1'b0) begin errors++; $display("FAIL correct_hp_wrong got %0d %b exp 3 0", HP_OUT, WRONG_OUT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL correct_busy_fall got %b exp 0", BUSY); end
    endtask

    task automatic test_signed();
        ask(-1, -6);
        enter(-3);
        enter(2);
        tick();
        checks++; if (JUDG_OUT !== 2'b01 || WRONG_OUT !== 1'b0) begin errors++; $display("FAIL signed_judg got %b %b exp 01 0", JUDG_OUT, WRONG_OUT); end
        tick();
        checks++; if (JUDG_OUT !== 2'b01) begin errors++; $display("FAIL signed_show_hold got %b exp 01", JUDG_OUT); end
    endtask

    task automatic test_wrong_over();
        for (int i = 0; i < 3; i++) begin
            ask(5, 6);
            enter(1);
            enter(6);
            checks++; if (WRONG_OUT !== 1'b0) begin errors++; $display("FAIL wrong_early_pulse round %0d got %b exp 0", i, WRONG_OUT); end
            tick();
            checks++; if (WRONG_OUT !== 1'b1) begin errors++; $display("FAIL wrong_pulse round %0d got %b exp 1", i, WRONG_OUT); end
            checks++; if (HP_OUT !== 2'(2 - i)) begin errors++; $display("FAIL wrong_hp round %0d got %0d exp %0d", i, HP_OUT, 2 - i); end
            checks++; if (JUDG_OUT !== ((i == 2) ? 2'b11 : 2'b10)) begin errors++; $display("FAIL wrong_judg round %0d got %b", i, JUDG_OUT); end
            tick();
            checks++; if (WRONG_OUT !== 1'b0) begin errors++; $display("FAIL wrong_pulse_width round %0d got %b exp 0", i, WRONG_OUT); end
        end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL over_busy got %b exp 0", BUSY); end
        ask(5, 6);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL over_ignore_que got busy %b exp 0", BUSY); end
        enter(2);
        enter(3);
        tick();
        checks++; if (JUDG_OUT !== 2'b11 || HP_OUT !== 2'd0 || WRONG_OUT !== 1'b0) begin errors++; $display("FAIL over_sticky got %b %0d %b exp 11 0 0", JUDG_OUT, HP_OUT, WRONG_OUT); end
        RST = 1'b0;
        tick();
        RST = 1'b1;
        checks++; if (JUDG_OUT !== 2'b00 || HP_OUT !== 2'd3) begin errors++; $display("FAIL over_reset got %b %0d exp 00 3", JUDG_OUT, HP_OUT); end
        tick();
    endtask

    task automatic test_timeout();
        ask(5, 6);
        repeat (TL) tick();
        checks++; if (JUDG_OUT !== 2'b00 || BUSY !== 1'b1) begin errors++; $display("FAIL timeout_early got %b busy %b exp 00 1", JUDG_OUT, BUSY); end
        tick();
        checks++; if (JUDG_OUT !== 2'b10 || WRONG_OUT !== 1'b1) begin errors++; $display("FAIL timeout_judg got %b %b exp 10 1", JUDG_OUT, WRONG_OUT); end
        checks++; if (HP_OUT !== 2'd2) begin errors++; $display("FAIL timeout_hp got %0d exp 2", HP_OUT); end
        tick();
    endtask

    task automatic test_expiry_enter();
        ask(5, 6);
        enter(2);
        repeat (TL - 2) tick();
        enter(3);
        tick();
        checks++; if (JUDG_OUT !== 2'b01 || WRONG_OUT !== 1'b0) begin errors++; $display("FAIL expiry_enter got %b %b exp 01 0", JUDG_OUT, WRONG_OUT); end
        checks++; if (HP_OUT !== 2'd2) begin errors++; $display("FAIL expiry_enter_hp got %0d exp 2", HP_OUT); end
    endtask

    task automatic test_clr();
        ask(5, 6);
        CLR = 1'b1; tick(); CLR = 1'b0;      // no effect in GET_P
        enter(1);
        ask(0, 0);                            // ignored while open
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL clr_busy got %b exp 1", BUSY); end
        CLR = 1'b1; tick(); CLR = 1'b0;       // back to GET_P
        enter(2);
        CLR = 1'b1;                           // ENTER beats CLR
        enter(3);
        CLR = 1'b0;
        tick();
        checks++; if (JUDG_OUT !== 2'b01 || WRONG_OUT !== 1'b0) begin errors++; $display("FAIL clr_judg got %b %b exp 01 0", JUDG_OUT, WRONG_OUT); end
    endtask

    task automatic test_reset_mid();
        ask(5, 6);
        enter(1);
        enter(6);
        tick();
        checks++; if (HP_OUT !== 2'd1) begin errors++; $display("FAIL mid_pre_hp got %0d exp 1", HP_OUT); end
        ask(5, 6);
        enter(2);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        checks++; if (JUDG_OUT !== 2'b00 || HP_OUT !== 2'd3) begin errors++; $display("FAIL mid_reset got %b %0d exp 00 3", JUDG_OUT, HP_OUT); end
        checks++; if (BUSY !== 1'b0 || WRONG_OUT !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b %b exp 0 0", BUSY, WRONG_OUT); end
        enter(3);
        tick();
        checks++; if (BUSY !== 1'b0 || WRONG_OUT !== 1'b0 || JUDG_OUT !== 2'b00) begin errors++; $display("FAIL mid_idle got %b %b %b exp 0 0 00", BUSY, WRONG_OUT, JUDG_OUT); end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_signed();
        test_wrong_over();
        test_timeout();
        test_expiry_enter();
        test_clr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/factor_judge.md
# factor_judge

Answer-judging stage feeding the game controller. Latches a question (x² + b·x + c), collects the player's two factor constants p and q, checks (x+p)(x+q) against the question, and maintains hit points. Its JUDG_OUT, WRONG_OUT and HP_OUT drive the controller's JUDG_IN, WRONG_IN and HP_IN directly.

## Interface
- P_W, 5: width of the signed factor entries p and q, range −(2^(P_W−1)−1)..+(2^(P_W−1)−1).
- TIME_LIMIT, 1024: answer window in cycles per question. Must be ≥ 2.
- HP_INIT, 3: starting hit points, 1..3.

- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- QUE_VALID  in  1  1-cycle pulse: new question present on QUE_B and QUE_C.
- QUE_B  in  P_W+1  signed coefficient b.
- QUE_C  in  2·P_W  signed coefficient c.
- ANS_IN  in  P_W  signed entry value.
- ENTER  in  1  1-cycle pulse: commit ANS_IN.
- CLR  in  1  1-cycle pulse: discard the last committed entry.
- JUDG_OUT  out  2  00 none, 01 correct, 10 wrong, 11 game over.
- WRONG_OUT  out  1  1-cycle pulse for every wrong or timed-out answer.
- HP_OUT  out  2  remaining hit points.
- BUSY  out  1  high while a question is open (GET_P, GET_Q, CHECK).

## Operation
- States: IDLE, GET_P, GET_Q, CHECK, SHOW, OVER.
- IDLE or SHOW + QUE_VALID: latch b and c, clear the timer, set JUDG_OUT=00, go to GET_P.
- GET_P + ENTER: latch p = ANS_IN, go to GET_Q. CLR in GET_P has no effect.
- GET_Q + ENTER: latch q, go to CHECK. GET_Q + CLR: discard p, go to GET_P. If ENTER and CLR arrive together, ENTER wins.
- Timer runs only in GET_P and GET_Q, and keeps counting across a CLR.
- Timeout: if the timer reaches TIME_LIMIT−1 with no ENTER in that same cycle, go to CHECK with a forced mismatch. In GET_Q, ENTER in the expiry cycle wins and the answer is judged normally.
- Match rule in CHECK: (p+q) == b and p·q == c.
  - Sum is computed at P_W+1 bits signed, product at 2·P_W bits signed, with no truncation.
  - The rule is symmetric in p and q.
- CHECK lasts one cycle.
  - Match: JUDG_OUT=01, go to SHOW.
  - Mismatch: JUDG_OUT=10, WRONG_OUT pulses, HP decrements. If the new HP is 0, JUDG_OUT=11 and go to OVER; otherwise go to SHOW.
- SHOW holds JUDG_OUT and HP_OUT until the next QUE_VALID.
- OVER is sticky: every input is ignored until RST=0.
- QUE_VALID in GET_P, GET_Q or CHECK is ignored; the open question is not replaced.
- HP never underflows and never increments.

## Timing
- Values while RST=0 (all outputs registered): JUDG_OUT=00, WRONG_OUT=0, HP_OUT=HP_INIT, BUSY=0, state IDLE, timer 0, p=q=b=c=0.
- Reset mid-question returns to IDLE and HP to HP_INIT. No WRONG_OUT pulse is produced.
- QUE_VALID at edge n: BUSY=1 from n+1.
- Final ENTER at edge n: CHECK during n+1; JUDG_OUT, WRONG_OUT and HP_OUT are updated at edge n+2, all in the same cycle.
- BUSY falls together with the JUDG_OUT update.
- WRONG_OUT is high for exactly one cycle per wrong judgement.
- Timeout: JUDG_OUT=10 is valid TIME_LIMIT+1 cycles after the QUE_VALID edge, provided no final ENTER occurred.

## Structure
- Shared package factor_pkg holds:
  - the state enum (3 bits);
  - the JUDG codes JUDG_NONE, JUDG_OK, JUDG_NG, JUDG_OVER;
  - HP_W = 2.
- The controller imports the same JUDG codes.
- One sub-module, factor_check: combinational sum/product compare taking p, q, b, c and returning match. It is reused later by the question generator for self-check.

## Test plan
- b=5, c=6; ENTER p=2 then q=3 → JUDG_OUT=01 two cycles after the second ENTER, HP_OUT=3, no WRONG_OUT.
- b=−1, c=−6; p=−3, q=2 → JUDG_OUT=01, confirming signed handling and order independence.
- b=5, c=6; p=1, q=6 → JUDG_OUT=10, one WRONG_OUT pulse, HP_OUT=2. Three such questions in a row → HP_OUT=0, JUDG_OUT=11, BUSY=0; a further QUE_VALID and ENTER change nothing until RST.
- TIME_LIMIT=16; QUE_VALID, then no ENTER → JUDG_OUT=10 and WRONG_OUT at cycle 17, HP_OUT=2. Repeat with ENTER q coinciding with expiry and correct factors → JUDG_OUT=01.
- In GET_Q, CLR then ENTER p=2, q=3 → the new p is used and the result is JUDG_OUT=01. A QUE_VALID with b=0 during GET_Q is ignored.
- RST=0 for one cycle while in GET_Q after one wrong answer → IDLE, HP_OUT=3, JUDG_OUT=00, no WRONG_OUT.
